// File: rtl/e203_thread_sched_pkg.sv
// Shared definitions for the two-thread scheduler: thread count,
// FSM state encoding and switch counter width.
package e203_thread_sched_pkg;

    localparam int unsigned E203_THREADS_NUM  = 2;
    localparam int unsigned E203_SWITCH_CNT_W = 16;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_SWITCH = 2'd2
    } sched_state_e;

endpackage

// File: rtl/e203_thread_sched_if.sv
// Scheduler control bus: core-side status inputs and thread-select outputs.
interface e203_thread_sched_if
    import e203_thread_sched_pkg::*;
#(
    parameter int unsigned THREADS_NUM = E203_THREADS_NUM,
    parameter int unsigned SLICE_W     = 16
);

    logic [SLICE_W-1:0]           slice_len;
    logic [THREADS_NUM-1:0]       thr_active;
    logic [THREADS_NUM-1:0]       thr_irq;
    logic                         allow_switch;
    logic                         pipe_idle;
    logic [THREADS_NUM-1:0]       thread_sel;
    logic                         cur_tid;
    logic                         fetch_hold;
    logic                         switch_flush;
    logic [E203_SWITCH_CNT_W-1:0] switch_cnt;

    modport master (
        output slice_len, thr_active, thr_irq, allow_switch, pipe_idle,
        input  thread_sel, cur_tid, fetch_hold, switch_flush, switch_cnt
    );

    modport slave (
        input  slice_len, thr_active, thr_irq, allow_switch, pipe_idle,
        output thread_sel, cur_tid, fetch_hold, switch_flush, switch_cnt
    );

endinterface

// File: rtl/e203_thread_sched_slice_timer.sv
// Time-slice counter: counts while enabled, saturates at slice_len-1,
// synchronous clear via load_i. Expiry is evaluated against the live
// slice_len so a shortened slice takes effect at once.
module e203_thread_slice_timer #(
    parameter int unsigned SLICE_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en_i,
    input  logic               load_i,
    input  logic [SLICE_W-1:0] slice_len_i,
    output logic               expire_o
);

    logic [SLICE_W-1:0] cnt_q;
    logic [SLICE_W-1:0] cnt_d;
    logic [SLICE_W-1:0] limit;

    // slice_len of 0 wraps the limit to all-ones, so the counter just parks there
    assign limit = slice_len_i - SLICE_W'(1);

    // next count: clear has priority, otherwise saturating increment
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q < limit)) begin
            cnt_d = cnt_q + SLICE_W'(1);
        end
    end

    // counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = (slice_len_i != '0) && (cnt_q >= limit);

endmodule

// File: rtl/e203_thread_sched.sv
// Two-thread context scheduler: RUN -> DRAIN -> SWITCH -> RUN.
// Thread select is driven only from registered state, so drain handshake
// inputs never reach thread_sel combinationally.
module e203_thread_sched
    import e203_thread_sched_pkg::*;
#(
    parameter int unsigned THREADS_NUM = E203_THREADS_NUM,
    parameter int unsigned SLICE_W     = 16
) (
    input logic                clk,
    input logic                rst,
    e203_thread_sched_if.slave bus
);

    sched_state_e                 state_q;
    sched_state_e                 state_d;
    logic                         cur_tid_q;
    logic                         cur_tid_d;
    logic [E203_SWITCH_CNT_W-1:0] switch_cnt_q;
    logic [E203_SWITCH_CNT_W-1:0] switch_cnt_d;

    logic other_tid;
    logic eligible;
    logic cur_active;
    logic irq_pref;
    logic expire;
    logic trigger;
    logic abort;
    logic timer_en;
    logic timer_load;

    assign other_tid  = ~cur_tid_q;
    assign eligible   = bus.thr_active[other_tid];
    assign cur_active = bus.thr_active[cur_tid_q];
    assign irq_pref   = bus.thr_irq[other_tid] & ~bus.thr_irq[cur_tid_q];
    assign trigger    = eligible & (expire | ~cur_active | irq_pref);
    assign abort      = (state_q == ST_DRAIN) && !eligible;

    assign timer_en   = (state_q == ST_RUN);
    assign timer_load = (state_q == ST_SWITCH) || abort;

    e203_thread_slice_timer #(
        .SLICE_W (SLICE_W)
    ) u_slice_timer (
        .clk         (clk),
        .rst         (rst),
        .en_i        (timer_en),
        .load_i      (timer_load),
        .slice_len_i (bus.slice_len),
        .expire_o    (expire)
    );

    // next-state: abort is checked before the drain-complete condition
    always_comb begin
        state_d      = state_q;
        cur_tid_d    = cur_tid_q;
        switch_cnt_d = switch_cnt_q;
        case (state_q)
            ST_RUN: begin
                if (trigger) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!eligible) begin
                    state_d = ST_RUN;
                end else if (bus.allow_switch && bus.pipe_idle) begin
                    state_d = ST_SWITCH;
                end
            end
            ST_SWITCH: begin
                state_d      = ST_RUN;
                cur_tid_d    = ~cur_tid_q;
                switch_cnt_d = switch_cnt_q + E203_SWITCH_CNT_W'(1);
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // state, thread index and switch counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_RUN;
            cur_tid_q    <= 1'b0;
            switch_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            cur_tid_q    <= cur_tid_d;
            switch_cnt_q <= switch_cnt_d;
        end
    end

    assign bus.thread_sel   = THREADS_NUM'(1) << cur_tid_q;
    assign bus.cur_tid      = cur_tid_q;
    assign bus.fetch_hold   = (state_q == ST_DRAIN) || (state_q == ST_SWITCH);
    assign bus.switch_flush = (state_q == ST_SWITCH);
    assign bus.switch_cnt   = switch_cnt_q;

endmodule

// File: tb/tb_e203_thread_sched.sv
// Directed bench for e203_thread_sched. Cycle 0 is the first cycle after
// the reset edge; outputs are sampled on the falling edge.
module tb_e203_thread_sched;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tot = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    e203_thread_sched_if #(.THREADS_NUM(2), .SLICE_W(16)) bus ();

    e203_thread_sched #(
        .THREADS_NUM (2),
        .SLICE_W     (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    task automatic set_in(input logic [15:0] len, input logic [1:0] act,
                          input logic [1:0] irq, input logic allow, input logic idle);
        bus.slice_len    = len;
        bus.thr_active   = act;
        bus.thr_irq      = irq;
        bus.allow_switch = allow;
        bus.pipe_idle    = idle;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
        chk("onehot", 32'($onehot(bus.thread_sel)), 1);
        chk("tid_idx", bus.cur_tid, bus.thread_sel[1]);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int cnt;

        // slice expiry, slice_len=8
        set_in(16'd8, 2'b11, 2'b00, 1'b1, 1'b1);
        do_reset();
        chk("rst_sel", bus.thread_sel, 2'b01);
        chk("rst_tid", bus.cur_tid, 0);
        chk("rst_hold", bus.fetch_hold, 0);
        chk("rst_flush", bus.switch_flush, 0);
        chk("rst_cnt", bus.switch_cnt, 0);
        cnt = 0;
        for (int i = 1; i <= 7; i++) begin
            step(1);
            if (bus.switch_flush || bus.fetch_hold) cnt++;
        end
        chk("exp_early", cnt, 0);
        step(1);
        chk("exp_hold8", bus.fetch_hold, 1);
        chk("exp_flush8", bus.switch_flush, 0);
        step(1);
        chk("exp_flush9", bus.switch_flush, 1);
        chk("exp_sel9", bus.thread_sel, 2'b01);
        step(1);
        chk("exp_sel10", bus.thread_sel, 2'b10);
        chk("exp_cnt10", bus.switch_cnt, 1);
        chk("exp_flush10", bus.switch_flush, 0);
        chk("exp_hold10", bus.fetch_hold, 0);
        step(10);
        chk("exp_sel20", bus.thread_sel, 2'b01);
        chk("exp_cnt20", bus.switch_cnt, 2);

        // thread 0 halted, slicing disabled
        set_in(16'd0, 2'b10, 2'b00, 1'b1, 1'b1);
        do_reset();
        chk("halt_hold0", bus.fetch_hold, 0);
        step(1);
        chk("halt_hold1", bus.fetch_hold, 1);
        step(1);
        chk("halt_flush2", bus.switch_flush, 1);
        step(1);
        chk("halt_sel3", bus.thread_sel, 2'b10);
        chk("halt_cnt3", bus.switch_cnt, 1);
        cnt = 0;
        for (int i = 0; i < 30; i++) begin
            step(1);
            if (bus.switch_flush || bus.fetch_hold) cnt++;
        end
        chk("halt_quiet", cnt, 0);
        chk("halt_sel_end", bus.thread_sel, 2'b10);
        chk("halt_cnt_end", bus.switch_cnt, 1);

        // drain stall: pipe busy for 5 cycles
        set_in(16'd0, 2'b11, 2'b10, 1'b1, 1'b0);
        do_reset();
        step(1);
        for (int i = 1; i <= 5; i++) begin
            chk("stall_hold", bus.fetch_hold, 1);
            chk("stall_flush", bus.switch_flush, 0);
            if (i < 5) step(1);
        end
        bus.pipe_idle = 1'b1;
        step(1);
        chk("stall_flush6", bus.switch_flush, 1);
        step(1);
        chk("stall_sel7", bus.thread_sel, 2'b10);
        chk("stall_cnt7", bus.switch_cnt, 1);

        // abort beats a same-cycle drain completion
        set_in(16'd0, 2'b11, 2'b10, 1'b1, 1'b0);
        do_reset();
        step(1);
        chk("abort_hold1", bus.fetch_hold, 1);
        bus.thr_active = 2'b01;
        bus.pipe_idle  = 1'b1;
        step(1);
        chk("abort_hold2", bus.fetch_hold, 0);
        chk("abort_flush2", bus.switch_flush, 0);
        chk("abort_sel2", bus.thread_sel, 2'b01);
        chk("abort_cnt2", bus.switch_cnt, 0);
        step(1);
        chk("abort_hold3", bus.fetch_hold, 0);

        // irq preempt, reset lands during SWITCH
        set_in(16'd0, 2'b11, 2'b10, 1'b1, 1'b1);
        do_reset();
        step(1);
        chk("irq_hold1", bus.fetch_hold, 1);
        step(1);
        chk("irq_flush2", bus.switch_flush, 1);
        rst = 1'b1;
        step(1);
        chk("irq_rst_sel", bus.thread_sel, 2'b01);
        chk("irq_rst_cnt", bus.switch_cnt, 0);
        chk("irq_rst_flush", bus.switch_flush, 0);
        chk("irq_rst_hold", bus.fetch_hold, 0);
        bus.thr_irq = 2'b00;
        rst = 1'b0;

        // slice shortened mid-slice fires at once
        set_in(16'd100, 2'b11, 2'b00, 1'b1, 1'b1);
        do_reset();
        step(10);
        chk("len_hold10", bus.fetch_hold, 0);
        bus.slice_len = 16'd4;
        step(1);
        chk("len_hold11", bus.fetch_hold, 1);
        step(1);
        chk("len_flush12", bus.switch_flush, 1);
        step(1);
        chk("len_sel13", bus.thread_sel, 2'b10);

        // slice_len=1: back-to-back minimum-latency switches
        set_in(16'd1, 2'b11, 2'b00, 1'b1, 1'b1);
        do_reset();
        step(3);
        chk("len1_sel3", bus.thread_sel, 2'b10);
        chk("len1_cnt3", bus.switch_cnt, 1);
        step(3);
        chk("len1_sel6", bus.thread_sel, 2'b01);
        chk("len1_cnt6", bus.switch_cnt, 2);

        // both threads inactive
        set_in(16'd4, 2'b00, 2'b11, 1'b1, 1'b1);
        do_reset();
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            step(1);
            if (bus.switch_flush || bus.fetch_hold) cnt++;
        end
        chk("idle_quiet", cnt, 0);
        chk("idle_sel", bus.thread_sel, 2'b01);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
